// File: rtl/arashi_rd_sched.sv
// Round-robin read scheduler: shares one memory read port among THREAD_NUM
// threads, tracks in-flight reads in an in-order tag FIFO and routes each
// returned word back to the thread that issued it.
module arashi_rd_sched #(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_WIDTH        = 16,
    parameter int THREAD_NUM_WIDTH = 2,
    parameter int MAX_OUTSTANDING  = 4,
    localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [THREAD_NUM-1:0]            req_valid,
    input  logic [THREAD_NUM*MEM_WIDTH-1:0]  req_addr,
    output logic [THREAD_NUM-1:0]            req_ready,
    output logic                             mem_valid,
    output logic [MEM_WIDTH-1:0]             mem_addr,
    output logic [THREAD_NUM_WIDTH-1:0]      mem_tag,
    input  logic                             mem_ready,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [THREAD_NUM-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [THREAD_NUM-1:0]            busy,
    output logic                             err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // FIFO pointers wrap at the configured depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic                        mem_valid_q, mem_valid_d;
    logic [MEM_WIDTH-1:0]        mem_addr_q, mem_addr_d;
    logic [THREAD_NUM_WIDTH-1:0] mem_tag_q, mem_tag_d;
    logic [THREAD_NUM-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
    logic [THREAD_NUM-1:0]       busy_q, busy_d;
    logic                        err_q, err_d;
    logic [THREAD_NUM_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [THREAD_NUM_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
    logic [THREAD_NUM_WIDTH-1:0] fifo_d [MAX_OUTSTANDING];

    logic                        slot_free_s;
    logic                        credit_s;
    logic                        found_s;
    logic                        grant_s;
    logic [THREAD_NUM_WIDTH-1:0] cand_s;
    logic [THREAD_NUM_WIDTH-1:0] grant_idx_s;
    logic                        pop_s;
    logic                        err_set_s;
    logic [THREAD_NUM_WIDTH-1:0] head_tag_s;

    // Rotating-priority search for the next eligible thread, gated by slot and credit.
    always_comb begin
        found_s     = 1'b0;
        cand_s      = {THREAD_NUM_WIDTH{1'b0}};
        grant_idx_s = {THREAD_NUM_WIDTH{1'b0}};
        slot_free_s = !mem_valid_q || mem_ready;
        // A response popping this cycle frees a credit for a same-cycle grant.
        credit_s    = (cnt_q < MAX_CNT) || mem_rvalid;
        for (int k = 0; k < THREAD_NUM; k++) begin
            cand_s = rr_ptr_q + THREAD_NUM_WIDTH'(k);
            if (!found_s && req_valid[cand_s] && !busy_q[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
            end
        end
        grant_s = rstn && slot_free_s && credit_s && found_s;
        if (grant_s) begin
            req_ready = {{(THREAD_NUM-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready = {THREAD_NUM{1'b0}};
        end
    end

    // Next-state for the memory request register, tag FIFO, busy flags and responses.
    always_comb begin
        head_tag_s  = fifo_q[rd_ptr_q];
        pop_s       = mem_rvalid && (cnt_q != {CNT_W{1'b0}});
        err_set_s   = mem_rvalid && (cnt_q == {CNT_W{1'b0}});
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_tag_d   = mem_tag_q;
        busy_d      = busy_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        err_d       = err_q | err_set_s;

        if (pop_s) begin
            busy_d[head_tag_s] = 1'b0;
            rd_ptr_d           = ptr_inc(rd_ptr_q);
            rsp_valid_d        = {{(THREAD_NUM-1){1'b0}}, 1'b1} << head_tag_s;
            rsp_data_d         = mem_rdata;
        end else begin
            rsp_valid_d        = {THREAD_NUM{1'b0}};
            rsp_data_d         = rsp_data_q;
        end

        if (grant_s) begin
            mem_valid_d         = 1'b1;
            mem_addr_d          = req_addr[grant_idx_s*MEM_WIDTH +: MEM_WIDTH];
            mem_tag_d           = grant_idx_s;
            busy_d[grant_idx_s] = 1'b1;
            fifo_d[wr_ptr_q]    = grant_idx_s;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            rr_ptr_d            = grant_idx_s + THREAD_NUM_WIDTH'(1);
        end else if (mem_ready) begin
            mem_valid_d         = 1'b0;
        end else begin
            mem_valid_d         = mem_valid_q;
        end

        case ({grant_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous active-low reset discarding all in-flight reads.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= {MEM_WIDTH{1'b0}};
            mem_tag_q   <= {THREAD_NUM_WIDTH{1'b0}};
            rsp_valid_q <= {THREAD_NUM{1'b0}};
            rsp_data_q  <= {DATA_WIDTH{1'b0}};
            busy_q      <= {THREAD_NUM{1'b0}};
            err_q       <= 1'b0;
            rr_ptr_q    <= {THREAD_NUM_WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= {THREAD_NUM_WIDTH{1'b0}};
            end
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_tag_q   <= mem_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_tag   = mem_tag_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arashi_rd_sched.sv
// Bench for arashi_rd_sched: directed scenarios plus a randomized run checked
// against a queue-based reference model. A second instance with a credit cap
// of 2 shares the inputs for the credit-limit scenario.
module tb_arashi_rd_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [63:0] req_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [3:0]  req_ready,  req_ready_b;
    logic        mem_valid,  mem_valid_b;
    logic [15:0] mem_addr,   mem_addr_b;
    logic [1:0]  mem_tag,    mem_tag_b;
    logic [3:0]  rsp_valid,  rsp_valid_b;
    logic [31:0] rsp_data,   rsp_data_b;
    logic [3:0]  busy,       busy_b;
    logic        err,        err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arashi_rd_sched #(.DATA_WIDTH(32), .MEM_WIDTH(16), .THREAD_NUM_WIDTH(2), .MAX_OUTSTANDING(4)) u_dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_tag(mem_tag), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err));

    arashi_rd_sched #(.DATA_WIDTH(32), .MEM_WIDTH(16), .THREAD_NUM_WIDTH(2), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_b),
        .mem_valid(mem_valid_b), .mem_addr(mem_addr_b), .mem_tag(mem_tag_b), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .busy(busy_b), .err(err_b));

    task automatic do_reset();
        rstn = 1'b0; req_valid = 4'h0; req_addr = 64'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 4'hF; req_addr = 64'h0; mem_ready = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready: got %h exp 0", req_ready); end
        total++;
        if ({mem_valid, mem_addr, mem_tag, rsp_valid, rsp_data, busy, err} !== 60'h0) begin
            bad++; $display("FAIL reset_outputs: mv=%b addr=%h tag=%h rspv=%h rspd=%h busy=%h err=%b exp all 0",
                            mem_valid, mem_addr, mem_tag, rsp_valid, rsp_data, busy, err);
        end
        rstn = 1'b1; req_valid = 4'h0; #1;
        total++;
        if (req_ready !== 4'h0) begin bad++; $display("FAIL idle_ready: got %h exp 0", req_ready); end
        tick();
        total++;
        if ({mem_valid, rsp_valid, busy, err} !== 10'h0) begin
            bad++; $display("FAIL idle_outputs: mv=%b rspv=%h busy=%h err=%b exp 0", mem_valid, rsp_valid, busy, err);
        end
    endtask

    task automatic test_single();
        do_reset();
        mem_ready = 1'b1; req_valid = 4'b0100; req_addr = 64'h0000_1234_0000_0000; #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++;
        if ({mem_valid, mem_addr, mem_tag, busy} !== {1'b1, 16'h1234, 2'd2, 4'b0100}) begin
            bad++; $display("FAIL single_mem: mv=%b addr=%h tag=%0d busy=%b exp 1 1234 2 0100", mem_valid, mem_addr, mem_tag, busy);
        end
        tick();
        total++;
        if ({mem_valid, busy} !== {1'b0, 4'b0100}) begin
            bad++; $display("FAIL single_c2: mv=%b busy=%b exp 0 0100", mem_valid, busy);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        total++;
        if ({rsp_valid, busy} !== {4'b0000, 4'b0100}) begin
            bad++; $display("FAIL single_c3: rspv=%b busy=%b exp 0000 0100", rsp_valid, busy);
        end
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_data, busy} !== {4'b0100, 32'hDEAD_BEEF, 4'b0000}) begin
            bad++; $display("FAIL single_rsp: rspv=%b data=%h busy=%b exp 0100 deadbeef 0000", rsp_valid, rsp_data, busy);
        end
        tick();
        total++;
        if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_pulse: rspv=%b exp 0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic       mv_prev;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        do_reset();
        req_valid = 4'hF; req_addr = 64'h3333_2222_1111_0000; mem_ready = 1'b1; mv_prev = 1'b0;
        for (int c = 0; c < 16; c++) begin
            mem_rvalid = mv_prev;
            mem_rdata  = 32'hA000_0000 + 32'(c);
            #1;
            exp_ready = 4'b0001 << (c % 4);
            total++;
            if (req_ready !== exp_ready) begin
                bad++; $display("FAIL rr_grant c=%0d: got %b exp %b", c, req_ready, exp_ready);
            end
            mv_prev = mem_valid;
            tick();
            exp_rsp = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
            total++;
            if ({mem_valid, mem_tag, rsp_valid} !== {1'b1, 2'(c % 4), exp_rsp}) begin
                bad++; $display("FAIL rr_issue c=%0d: mv=%b tag=%0d rspv=%b exp 1 %0d %b", c, mem_valid, mem_tag, rsp_valid, c % 4, exp_rsp);
            end
            if (exp_rsp != 4'b0000) begin
                total++;
                if (rsp_data !== 32'hA000_0000 + 32'(c)) begin
                    bad++; $display("FAIL rr_data c=%0d: got %h exp %h", c, rsp_data, 32'hA000_0000 + 32'(c));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0011; req_addr = 64'h0000_0000_2222_1111; mem_ready = 1'b0; #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first: got %b exp 0001", req_ready); end
        tick();
        for (int c = 1; c <= 5; c++) begin
            total++;
            if ({mem_valid, mem_addr, mem_tag, req_ready} !== {1'b1, 16'h1111, 2'd0, 4'b0000}) begin
                bad++; $display("FAIL bp_hold c=%0d: mv=%b addr=%h tag=%0d ready=%b exp 1 1111 0 0000", c, mem_valid, mem_addr, mem_tag, req_ready);
            end
            tick();
        end
        mem_ready = 1'b1; #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_second: got %b exp 0010", req_ready); end
        tick();
        total++;
        if ({mem_valid, mem_addr, mem_tag} !== {1'b1, 16'h2222, 2'd1}) begin
            bad++; $display("FAIL bp_reload: mv=%b addr=%h tag=%0d exp 1 2222 1", mem_valid, mem_addr, mem_tag);
        end
    endtask

    task automatic test_credit();
        logic [3:0] exp_tab [4];
        exp_tab[0] = 4'b0001; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b0000; exp_tab[3] = 4'b0000;
        do_reset();
        req_valid = 4'hF; req_addr = 64'h4444_3333_2222_1111; mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (req_ready_b !== exp_tab[c]) begin
                bad++; $display("FAIL credit_grant c=%0d: got %b exp %b", c, req_ready_b, exp_tab[c]);
            end
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
        total++;
        if (req_ready_b !== 4'b0100) begin bad++; $display("FAIL credit_pop_grant: got %b exp 0100", req_ready_b); end
        tick();
        mem_rvalid = 1'b0; #1;
        total++;
        if ({rsp_valid_b, rsp_data_b, mem_valid_b, mem_tag_b, busy_b, req_ready_b} !==
            {4'b0001, 32'h5555_AAAA, 1'b1, 2'd2, 4'b0110, 4'b0000}) begin
            bad++; $display("FAIL credit_after: rspv=%b data=%h mv=%b tag=%0d busy=%b ready=%b exp 0001 5555aaaa 1 2 0110 0000",
                            rsp_valid_b, rsp_data_b, mem_valid_b, mem_tag_b, busy_b, req_ready_b);
        end
    endtask

    task automatic test_error_reset();
        do_reset();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({err, rsp_valid} !== {1'b1, 4'b0000}) begin
                bad++; $display("FAIL err_sticky c=%0d: err=%b rspv=%b exp 1 0000", c, err, rsp_valid);
            end
            tick();
        end
        do_reset();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b exp 0", err); end
        req_valid = 4'b0111; req_addr = 64'h0000_3000_2000_1000; mem_ready = 1'b1;
        repeat (3) tick();
        req_valid = 4'b0000;
        total++;
        if (busy !== 4'b0111) begin bad++; $display("FAIL three_busy: got %b exp 0111", busy); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++;
        if ({busy, err, mem_valid} !== 6'b0) begin
            bad++; $display("FAIL mid_reset: busy=%b err=%b mv=%b exp 0", busy, err, mem_valid);
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({err, rsp_valid} !== {1'b1, 4'b0000}) begin
            bad++; $display("FAIL late_rvalid: err=%b rspv=%b exp 1 0000", err, rsp_valid);
        end
    endtask

    task automatic test_random();
        bit          m_mv;
        logic [15:0] m_addr;
        logic [1:0]  m_tag;
        logic [3:0]  m_busy;
        logic [3:0]  m_rspv;
        logic [31:0] m_rspd;
        bit          m_err;
        int          m_rr;
        int          tagq[$];
        int          pend[$];
        int          g;
        int          t;
        bit          hs;
        logic [3:0]  exp_ready;
        do_reset();
        m_mv = 1'b0; m_addr = 16'h0; m_tag = 2'd0; m_busy = 4'h0; m_rspv = 4'h0;
        m_rspd = 32'h0; m_err = 1'b0; m_rr = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid  = 4'($urandom);
            req_addr   = {$urandom, $urandom};
            mem_ready  = ($urandom % 10) < 7;
            mem_rvalid = (pend.size() > 0) && (pend[0] < c) && (($urandom % 10) < 6);
            mem_rdata  = $urandom;
            #1;
            g = -1;
            if ((!m_mv || mem_ready) && (tagq.size() < 4 || mem_rvalid)) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % 4] && !m_busy[(m_rr + k) % 4]) g = (m_rr + k) % 4;
                end
            end
            exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            total++;
            if (req_ready !== exp_ready) begin
                bad++; $display("FAIL rand_ready c=%0d: got %b exp %b", c, req_ready, exp_ready);
            end
            hs = m_mv && mem_ready;
            if (mem_rvalid) begin
                if (tagq.size() == 0) begin
                    m_err = 1'b1; m_rspv = 4'h0;
                end else begin
                    t = tagq.pop_front();
                    m_busy[t] = 1'b0; m_rspv = 4'b0001 << t; m_rspd = mem_rdata;
                end
                void'(pend.pop_front());
            end else begin
                m_rspv = 4'h0;
            end
            if (g >= 0) begin
                m_mv = 1'b1; m_addr = req_addr[g*16 +: 16]; m_tag = 2'(g);
                m_busy[g] = 1'b1; tagq.push_back(g); m_rr = (g + 1) % 4;
            end else if (mem_ready) begin
                m_mv = 1'b0;
            end
            if (hs) pend.push_back(c);
            tick();
            total++;
            if ({mem_valid, busy, err, rsp_valid} !== {m_mv, m_busy, m_err, m_rspv}) begin
                bad++; $display("FAIL rand_state c=%0d: mv=%b busy=%b err=%b rspv=%b exp %b %b %b %b",
                                c, mem_valid, busy, err, rsp_valid, m_mv, m_busy, m_err, m_rspv);
            end
            if (m_mv) begin
                total++;
                if ({mem_addr, mem_tag} !== {m_addr, m_tag}) begin
                    bad++; $display("FAIL rand_mem c=%0d: addr=%h tag=%0d exp %h %0d", c, mem_addr, mem_tag, m_addr, m_tag);
                end
            end
            if (m_rspv != 4'h0) begin
                total++;
                if (rsp_data !== m_rspd) begin
                    bad++; $display("FAIL rand_data c=%0d: got %h exp %h", c, rsp_data, m_rspd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_credit();
        test_error_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arashi_rd_sched.md
Name: arashi_rd_sched

Overview:
- Round-robin read scheduler that shares one cache/memory read port among THREAD_NUM threads.
- Accepts one read request per thread, grants one per cycle in rotating priority order, and drives a registered valid/ready request to the memory port.
- Tracks outstanding reads in an in-order tag FIFO and steers each returned word back to its owning thread.
- Sits between the per-thread fetch logic and the shared cache read port.

Parameters:
- DATA_WIDTH, 32: width of read data.
- MEM_WIDTH, 16: width of read address.
- THREAD_NUM_WIDTH, 2: log2 of the thread count; THREAD_NUM = 1 << THREAD_NUM_WIDTH. Legal values 1..4.
- MAX_OUTSTANDING, 4: cap on reads issued but not yet returned. Range 1..THREAD_NUM.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: reset, synchronous, active-low.
- req_valid, input, THREAD_NUM: per-thread read request.
- req_addr, input, THREAD_NUM*MEM_WIDTH: per-thread address; thread i uses bits [i*MEM_WIDTH +: MEM_WIDTH].
- req_ready, output, THREAD_NUM: one-hot grant, combinational; request i is accepted at the edge where req_valid[i] && req_ready[i].
- mem_valid, output, 1: registered read request to the memory port.
- mem_addr, output, MEM_WIDTH: registered address.
- mem_tag, output, THREAD_NUM_WIDTH: thread id of the current mem request.
- mem_ready, input, 1: memory accepts the request when mem_valid && mem_ready.
- mem_rvalid, input, 1: read data valid; responses return in issue order.
- mem_rdata, input, DATA_WIDTH: read data.
- rsp_valid, output, THREAD_NUM: registered one-hot response strobe.
- rsp_data, output, DATA_WIDTH: registered response data.
- busy, output, THREAD_NUM: thread has a read in flight (granted, not yet returned).
- err, output, 1: sticky protocol error.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - Cleared: mem_valid, mem_addr, mem_tag, rsp_valid, rsp_data, busy, err, round-robin pointer rr_ptr, outstanding count, FIFO pointers.
  - req_ready is 0 while rstn=0.
  - A reset mid-operation discards all in-flight state; late mem_rvalid after reset counts as a protocol error.
- Eligibility:
  - Thread i is eligible when req_valid[i] && !busy[i].
  - Each thread has at most one read in flight.
- Slot free condition: !mem_valid || mem_ready.
- Credit condition: outstanding_count < MAX_OUTSTANDING, or a response pops this cycle (mem_rvalid=1).
- Grant:
  - Issued only when the slot is free and credit is available.
  - Searches eligible threads starting at rr_ptr, wrapping modulo THREAD_NUM; the first hit wins.
  - At most one grant per cycle.
- On grant of thread g at edge N:
  - mem_valid=1, mem_addr=req_addr[g], mem_tag=g, all valid from N+1.
  - busy[g] set.
  - g pushed to the tag FIFO.
  - rr_ptr set to (g+1) modulo THREAD_NUM; the wrap uses a THREAD_NUM_WIDTH-bit add.
- No grant:
  - mem_valid is held with a stable address and tag until mem_ready.
  - mem_valid clears after acceptance if no new grant is made.
  - rr_ptr is unchanged.
- Back-to-back: a grant in the same cycle as mem_ready=1 reloads the register, giving full throughput of one read per cycle.
- Outstanding count:
  - +1 on grant, -1 on mem_rvalid; both in one cycle leaves it unchanged.
  - Tag FIFO depth is MAX_OUTSTANDING.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
- Response (mem_rvalid at edge M):
  - FIFO head t popped.
  - In cycle M+1: rsp_valid = one-hot(t), rsp_data = mem_rdata.
  - busy[t] clears at edge M; thread t is eligible again at cycle M+1's grant.
  - rsp_valid is a single-cycle pulse, with no backpressure from threads.
- Error: mem_rvalid while the FIFO is empty sets err. err is held until reset; nothing is popped and rsp_valid stays 0.
- Earliest response: mem_rvalid is earliest one cycle after the mem handshake. Total latency from req handshake to rsp_valid is at least 3 cycles.

Test Plan:
- Reset and idle: rstn=0 for 2 cycles, then req_valid=0 → all outputs 0 and req_ready=0.
- Single request: THREAD_NUM_WIDTH=2, mem_ready=1, req_valid=4'b0100 with addr 0x1234; memory returns 0xDEADBEEF 2 cycles after its handshake → required response:
  - req_ready=4'b0100 in cycle 0.
  - mem_valid, mem_addr=0x1234, mem_tag=2 in cycle 1.
  - rsp_valid=4'b0100, rsp_data=0xDEADBEEF in cycle 4.
  - busy[2] high during cycles 1-3.
- Round-robin fairness: req_valid=4'b1111 held, memory answering each read 1 cycle later → grants 0,1,2,3,0,…; one mem_valid handshake per cycle while credits last; no thread starved.
- Backpressure: mem_ready=0 for 5 cycles with 2 threads requesting → required response:
  - mem_addr and mem_tag stable for those 5 cycles.
  - No second grant until mem_ready=1.
  - The second grant lands on the cycle mem_ready rises.
- Credit limit: MAX_OUTSTANDING=2, mem_rvalid held off → exactly 2 grants, then req_ready=0. Asserting mem_rvalid produces a new grant in that same cycle.
- Error and reset mid-flight:
  - mem_rvalid with nothing outstanding → err=1 next cycle and stays 1.
  - Reset with 3 reads outstanding → busy=0 and err=0 after reset.
